// File: rtl/gaussian_row_conv_n.sv
// Horizontal stage of the separable Gaussian blur: odd-length 1-D kernel over a raster stream,
// WIDTH centred outputs per row with edge substitution. ROWCONV_ROUND_EN selects round-half-up.
module gaussian_row_conv_n #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TAPS      = 5,
    parameter int unsigned COEF_W    = 8,
    parameter logic [TAPS*COEF_W-1:0] COEFFS = {8'd1, 8'd4, 8'd6, 8'd4, 8'd1},
    parameter int unsigned SHIFT     = 4,
    parameter int unsigned EDGE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int unsigned R     = (TAPS - 1) / 2;
    localparam int          RI    = int'(R);
    localparam int          WI    = int'(WIDTH);
    localparam int          TI    = int'(TAPS);
    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned IDX_W = $clog2(TAPS);
    localparam int unsigned FL_W  = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned SUM_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int unsigned EXT_W = SUM_W + 1;
    localparam logic [DATA_W-1:0] PIX_MAX = '1;

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t state, state_nxt;

    logic              ready_en;
    logic [COL_W-1:0]  col;
    logic [FL_W-1:0]   fcnt;
    logic [DATA_W-1:0] hist [TAPS-1];
    logic [SUM_W-1:0]  sum_q;
    logic              sum_valid;
    logic              sum_last;

    logic              advance_c;
    logic              in_beat_c;
    logic              flush_adv_c;
    logic              step_c;
    logic              emit_c;
    logic              last_c;
    logic [DATA_W-1:0] win_c [TAPS];
    logic [DATA_W-1:0] tap_c [TAPS];
    logic [SUM_W-1:0]  sum_c;
    logic [EXT_W-1:0]  ext_c;
    logic [EXT_W-1:0]  shr_c;
    logic [DATA_W-1:0] res_c;

    assign advance_c = !out_valid || out_ready;
    assign in_beat_c = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (in_beat_c && col == COL_W'(R))         state_nxt = S_RUN;
            S_RUN:   if (in_beat_c && col == COL_W'(WIDTH - 1)) state_nxt = S_FLUSH;
            S_FLUSH: if (advance_c && fcnt == FL_W'(R - 1))     state_nxt = S_FILL;
            default:                                            state_nxt = S_FILL;
        endcase
    end

    // FSM outputs: handshake and pipeline-entry controls
    always_comb begin
        in_ready    = ready_en && advance_c && (state != S_FLUSH);
        flush_adv_c = (state == S_FLUSH) && advance_c;
        step_c      = in_beat_c || flush_adv_c;
        emit_c      = flush_adv_c || (in_beat_c && col >= COL_W'(R));
        last_c      = flush_adv_c && (fcnt == FL_W'(R - 1));
    end

    // in_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            fcnt <= '0;
            for (int k = 0; k < TI - 1; k++) begin
                hist[k] <= '0;
            end
        end else begin
            if (in_beat_c) begin
                col <= (col == COL_W'(WIDTH - 1)) ? '0 : col + COL_W'(1);
            end
            if (flush_adv_c) begin
                fcnt <= (fcnt == FL_W'(R - 1)) ? '0 : fcnt + FL_W'(1);
            end
            if (step_c) begin
                hist[0] <= win_c[0];
                for (int k = 1; k < TI - 1; k++) begin
                    hist[k] <= hist[k-1];
                end
            end
        end
    end

    // Window after this step: index 0 is the newest column; flush shifts in a dummy zero
    always_comb begin
        win_c[0] = (state == S_FLUSH) ? '0 : in_data;
        for (int k = 1; k < TI; k++) begin
            win_c[k] = hist[k-1];
        end
    end

    // Gather taps with edge substitution; newest window entry is column oc+R
    always_comb begin : gather
        int  oc;
        int  x;
        int  k;
        int  j;
        logic zero;
        oc = (state == S_FLUSH) ? (WI - RI + int'(fcnt)) : (int'(col) - RI);
        x    = 0;
        k    = 0;
        j    = 0;
        zero = 1'b0;
        for (int i = 0; i < TI; i++) begin
            x    = oc - RI + i;
            j    = 2 * RI - i;
            zero = 1'b0;
            if (x < 0) begin
                k = -x;
                case (EDGE_MODE)
                    1:       j = oc + RI - k;
                    2:       zero = 1'b1;
                    default: j = oc + RI;
                endcase
            end else if (x > WI - 1) begin
                k = x - (WI - 1);
                case (EDGE_MODE)
                    1:       j = oc + RI - (WI - 1 - k);
                    2:       zero = 1'b1;
                    default: j = oc + RI - (WI - 1);
                endcase
            end
            if (j < 0)      j = 0;
            if (j > TI - 1) j = TI - 1;
            tap_c[i] = zero ? '0 : win_c[IDX_W'(j)];
        end
    end

    // Multiply-accumulate; tap 0 uses the MSB coefficient slice
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TI; i++) begin
            sum_c = sum_c + SUM_W'(tap_c[i]) * SUM_W'(COEFFS[(TI-1-i)*COEF_W +: COEF_W]);
        end
    end

`ifdef ROWCONV_ROUND_EN
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [EXT_W-1:0] RND = (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
    assign ext_c = EXT_W'(sum_q) + RND;
`else
    assign ext_c = EXT_W'(sum_q);
`endif
    assign shr_c = ext_c >> SHIFT;
    assign res_c = (shr_c > EXT_W'(PIX_MAX)) ? PIX_MAX : DATA_W'(shr_c);

    // Sum stage then output stage; both hold while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance_c) begin
            sum_valid <= emit_c;
            if (emit_c) begin
                sum_q    <= sum_c;
                sum_last <= last_c;
            end
            out_valid <= sum_valid;
            out_last  <= sum_valid && sum_last;
            if (sum_valid) begin
                out_data <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_gaussian_row_conv_n.sv
// Bench for gaussian_row_conv_n: four WIDTH=8 instances (replicate, mirror, zero, saturating kernel)
// share one stimulus stream and are checked against a plain-arithmetic row model.
module tb_gaussian_row_conv_n;

    localparam int W  = 8;
    localparam int NI = 4;
    localparam logic [39:0] DEF_CF = {8'd1, 8'd4, 8'd6, 8'd4, 8'd1};
    localparam logic [39:0] SAT_CF = {8'd2, 8'd4, 8'd6, 8'd4, 8'd2};

    typedef struct packed {
        logic [NI-1:0]      last;
        logic [NI-1:0][7:0] data;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] od [NI];
    logic       ov [NI];
    logic       ol [NI];
    logic       ir [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gaussian_row_conv_n #(
            .WIDTH(W), .DATA_W(8), .TAPS(5), .COEF_W(8),
            .COEFFS((g == 3) ? SAT_CF : DEF_CF), .SHIFT(4),
            .EDGE_MODE((g == 3) ? 0 : g)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
            .in_ready(ir[g]), .out_data(od[g]), .out_valid(ov[g]),
            .out_ready(out_ready), .out_last(ol[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    first_ov = -1;
    int    stall_cnt = 0;
    bit    rnd_ready = 1'b0;
    bit    rdy_snap = 1'b0;
    int    beat_cyc [W];
    logic [7:0] od_prev [NI];
    logic       ol_prev [NI];
    bit         stall_prev [NI];

    function automatic int coef(int g, int i);
        int d[5] = '{1, 4, 6, 4, 1};
        int s[5] = '{2, 4, 6, 4, 2};
        return (g == 3) ? s[i] : d[i];
    endfunction

    function automatic int pix(int g, int row[W], int x);
        int m = (g == 3) ? 0 : g;
        if (x >= 0 && x < W) return row[x];
        if (m == 2) return 0;
        if (m == 1) return (x < 0) ? row[-x] : row[2*(W-1) - x];
        return (x < 0) ? row[0] : row[W-1];
    endfunction

    function automatic int model_out(int g, int row[W], int c);
        int s = 0;
        for (int i = 0; i < 5; i++) s += coef(g, i) * pix(g, row, c - 2 + i);
`ifdef ROWCONV_ROUND_EN
        s += 8;
`endif
        s = s / 16;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic push_expected(input int row[W]);
        beat_t b;
        for (int c = 0; c < W; c++) begin
            for (int g = 0; g < NI; g++) begin
                b.data[g] = 8'(model_out(g, row, c));
                b.last[g] = (c == W - 1);
            end
            exp_q.push_back(b);
        end
    endtask

    // One clock: sample outputs at negedge, check stall stability, then drive out_ready after posedge
    task automatic tick();
        beat_t b;
        @(negedge clk);
        cyc++;
        rdy_snap = ir[0];
        if (first_ov < 0 && ov[0]) first_ov = cyc;
        if (rst_n && ov[0] && out_ready) begin
            for (int g = 0; g < NI; g++) begin
                b.data[g] = od[g];
                b.last[g] = ol[g];
            end
            got_q.push_back(b);
        end
        for (int g = 0; g < NI; g++) begin
            if (stall_prev[g] && rst_n) begin
                checks++;
                if (ov[g] !== 1'b1 || od[g] !== od_prev[g] || ol[g] !== ol_prev[g]) begin
                    failures++;
                    $display("FAIL stall_hold inst=%0d got v=%0b d=%0d l=%0b exp v=1 d=%0d l=%0b",
                             g, ov[g], od[g], ol[g], od_prev[g], ol_prev[g]);
                end
            end
            if (rst_n && ov[g] && !out_ready) begin
                checks++;
                if (ir[g] !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready inst=%0d got=%0b exp=0", g, ir[g]);
                end
            end
            stall_prev[g] = rst_n && ov[g] && !out_ready;
            od_prev[g]    = od[g];
            ol_prev[g]    = ol[g];
        end
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rnd_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic drive_row(input int row[W], input int max_gap, input int stall_at, input int ncols);
        bit acc;
        if (ncols == W) push_expected(row);
        for (int c = 0; c < ncols; c++) begin
            repeat ($urandom_range(0, max_gap)) begin
                in_valid = 1'b0;
                tick();
            end
            in_data  = 8'(row[c]);
            in_valid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 100 && !acc; k++) begin
                tick();
                if (rdy_snap) begin
                    acc = 1'b1;
                    beat_cyc[c] = cyc;
                end
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout col=%0d got=no_accept exp=accept", c);
            end
            if (c == stall_at) stall_cnt = 5;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_outputs(input string name);
        int n;
        for (int k = 0; k < 300 && got_q.size() < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (got_q[i].data[g] !== exp_q[i].data[g]) begin
                    failures++;
                    $display("FAIL %s_data beat=%0d inst=%0d got=%0d exp=%0d",
                             name, i, g, got_q[i].data[g], exp_q[i].data[g]);
                end
                checks++;
                if (got_q[i].last[g] !== exp_q[i].last[g]) begin
                    failures++;
                    $display("FAIL %s_last beat=%0d inst=%0d got=%0b exp=%0b",
                             name, i, g, got_q[i].last[g], exp_q[i].last[g]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (ov[g] !== 1'b0 || od[g] !== 8'd0 || ol[g] !== 1'b0 || ir[g] !== 1'b0) begin
                failures++;
                $display("FAIL %s inst=%0d got v=%0b d=%0d l=%0b rdy=%0b exp all 0",
                         name, g, ov[g], od[g], ol[g], ir[g]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        check_idle_outputs("reset_values");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (rdy_snap !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_early got=%0b exp=0", rdy_snap);
        end
        tick();
        checks++;
        if (rdy_snap !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise got=%0b exp=1", rdy_snap);
        end
    endtask

    task automatic test_constant();
        int row[W];
        int lowc = 0;
        for (int c = 0; c < W; c++) row[c] = 100;
        first_ov = -1;
        drive_row(row, 0, -1, W);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!rdy_snap) lowc++;
            else break;
        end
        checks++;
        if (lowc !== 2) begin
            failures++;
            $display("FAIL flush_ready_low got=%0d exp=2", lowc);
        end
        checks++;
        if (first_ov - beat_cyc[2] !== 2) begin
            failures++;
            $display("FAIL latency got=%0d exp=2", first_ov - beat_cyc[2]);
        end
        check_outputs("constant");
    endtask

    task automatic test_edges();
        int row[W];
        for (int c = 0; c < W; c++) row[c] = (c == 3) ? 255 : 0;
        drive_row(row, 0, -1, W);
        check_outputs("impulse");
        for (int c = 0; c < W; c++) row[c] = 10 * c;
        drive_row(row, 0, -1, W);
        check_outputs("ramp");
    endtask

    task automatic test_backpressure();
        int row[W];
        for (int c = 0; c < W; c++) row[c] = 255;
        drive_row(row, 0, 4, W);
        check_outputs("saturate_stall");
    endtask

    task automatic test_back_to_back();
        int a[W];
        int b[W];
        for (int c = 0; c < W; c++) begin
            a[c] = $urandom_range(0, 255);
            b[c] = $urandom_range(0, 255);
        end
        drive_row(a, 0, -1, W);
        drive_row(b, 0, -1, W);
        check_outputs("back_to_back");
    endtask

    task automatic test_random();
        int row[W];
        rnd_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < W; c++) row[c] = $urandom_range(0, 255);
            drive_row(row, 2, -1, W);
            check_outputs("random");
        end
        rnd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_row();
        int row[W];
        for (int c = 0; c < W; c++) row[c] = $urandom_range(0, 255);
        drive_row(row, 0, -1, 5);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_row");
        got_q.delete();
        exp_q.delete();
        for (int g = 0; g < NI; g++) stall_prev[g] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        for (int c = 0; c < W; c++) row[c] = 100;
        drive_row(row, 0, -1, W);
        check_outputs("after_reset");
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            stall_prev[g] = 1'b0;
            od_prev[g]    = '0;
            ol_prev[g]    = 1'b0;
        end
        test_reset();
        test_constant();
        test_edges();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
